// File: rtl/i2c_pkg.sv
// Shared types and bus constants for the I2C target responder.
package i2c_pkg;

  // Protocol phases of the target state machine.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_t;

  // Bus level meaning ACK / NACK in the ninth clock.
  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  // R/W bit value that selects a read transfer.
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizer, glitch filter and edge detector for one I2C bus line.
// The filtered level only follows the synchronized input after FILTER_LEN
// consecutive differing samples, so shorter pulses never reach the FSM.
module i2c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic ref_clk,
  input  logic reset_n,
  input  logic line_in,
  output logic line_filt,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [3:0]             cnt_reg;
  logic                   filt_reg;
  logic                   rise_reg;
  logic                   fall_reg;
  logic                   sync_out;

  assign sync_out  = sync_reg[SYNC_STAGES-1];
  assign line_filt = filt_reg;
  assign rise      = rise_reg;
  assign fall      = fall_reg;

  // Metastability chain; resets to the idle (released, high) bus level.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) sync_reg <= '1;
    else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], line_in};
  end

  // Count consecutive samples disagreeing with the filtered level; flip and flag an edge on the last one.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_reg <= 1'b1;
      cnt_reg  <= '0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
      if (sync_out == filt_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == 4'(FILTER_LEN - 1)) begin
        filt_reg <= sync_out;
        cnt_reg  <= '0;
        rise_reg <= sync_out;
        fall_reg <= ~sync_out;
      end else begin
        cnt_reg <= cnt_reg + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target responder: fixed 7-bit address, byte handshake to user logic,
// open-drain SDA (pull low or release), no clock stretching.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       ref_clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy
);

  logic scl_filt, scl_rise, scl_fall;
  logic sda_filt, sda_rise, sda_fall;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .ref_clk(ref_clk), .reset_n(reset_n), .line_in(scl_in),
    .line_filt(scl_filt), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .ref_clk(ref_clk), .reset_n(reset_n), .line_in(sda_in),
    .line_filt(sda_filt), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_t state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       phase_reg, phase_next;     // 0: first scl_fall of an ACK slot pending, 1: second
  logic       rw_reg, rw_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       busy_reg, busy_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       tx_req_reg, tx_req_next;
  logic       start_reg, start_next;
  logic       stop_reg, stop_next;
  logic       start_cond, stop_cond;
  logic [7:0] rx_byte;

  // An SDA edge coinciding with an SCL edge is ambiguous after filtering; treat it as data.
  assign start_cond = sda_fall && scl_filt && !scl_rise && !scl_fall;
  assign stop_cond  = sda_rise && scl_filt && !scl_rise && !scl_fall;
  assign rx_byte    = {shift_reg[6:0], sda_filt};

  assign sda_oe    = sda_oe_reg;
  assign rx_data   = rx_data_reg;
  assign rx_valid  = rx_valid_reg;
  assign tx_req    = tx_req_reg;
  assign start_det = start_reg;
  assign stop_det  = stop_reg;
  assign busy      = busy_reg;

  // State and output registers; reset releases SDA without waiting for a clock edge.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_data_reg  <= '0;
      phase_reg    <= 1'b0;
      rw_reg       <= 1'b0;
      sda_oe_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      rx_valid_reg <= 1'b0;
      tx_req_reg   <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      phase_reg    <= phase_next;
      rw_reg       <= rw_next;
      sda_oe_reg   <= sda_oe_next;
      busy_reg     <= busy_next;
      rx_valid_reg <= rx_valid_next;
      tx_req_reg   <= tx_req_next;
      start_reg    <= start_next;
      stop_reg     <= stop_next;
    end
  end

  // Next-state logic: bus conditions first, then SCL-edge driven protocol steps.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    phase_next    = phase_reg;
    rw_next       = rw_reg;
    sda_oe_next   = sda_oe_reg;
    busy_next     = busy_reg;
    rx_valid_next = 1'b0;
    tx_req_next   = 1'b0;
    start_next    = 1'b0;
    stop_next     = 1'b0;

    if (start_cond) begin
      start_next   = 1'b1;
      state_next   = ADDR;
      bit_cnt_next = '0;
      phase_next   = 1'b0;
      sda_oe_next  = 1'b0;
      busy_next    = 1'b0;
    end else if (stop_cond) begin
      stop_next   = 1'b1;
      state_next  = IDLE;
      phase_next  = 1'b0;
      sda_oe_next = 1'b0;
      busy_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rw_next    = sda_filt;
              phase_next = 1'b0;
              // Address 0 (general call) never matches.
              if (rx_byte[7:1] == SLAVE_ADDR && SLAVE_ADDR != 7'h00) state_next = ADDR_ACK;
              else                                                 state_next = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              sda_oe_next = (I2C_ACK == 1'b0);
              busy_next   = 1'b1;
              tx_req_next = (rw_reg == I2C_RW_READ);
              phase_next  = 1'b1;
            end else begin
              phase_next   = 1'b0;
              bit_cnt_next = '0;
              if (rw_reg == I2C_RW_READ) begin
                shift_next  = tx_data;
                sda_oe_next = ~tx_data[7];
                state_next  = RD_DATA;
              end else begin
                sda_oe_next = 1'b0;
                state_next  = WR_DATA;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_next   = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              rx_data_next  = rx_byte;
              rx_valid_next = 1'b1;
              phase_next    = 1'b0;
              state_next    = WR_ACK;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!phase_reg) begin
              sda_oe_next = (I2C_ACK == 1'b0);
              phase_next  = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              phase_next   = 1'b0;
              bit_cnt_next = '0;
              state_next   = WR_DATA;
            end
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd7) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = '0;
              phase_next   = 1'b0;
              state_next   = RD_ACK;
            end else begin
              // Rotate so the next bit to send sits at the MSB.
              shift_next   = {shift_reg[6:0], shift_reg[7]};
              sda_oe_next  = ~shift_reg[6];
              bit_cnt_next = bit_cnt_reg + 3'd1;
            end
          end
        end
        RD_ACK: begin
          if (!phase_reg && scl_rise) begin
            if (sda_filt == I2C_NACK) begin
              busy_next  = 1'b0;
              state_next = IGNORE;
            end else begin
              tx_req_next = 1'b1;
              phase_next  = 1'b1;
            end
          end else if (phase_reg && scl_fall) begin
            shift_next   = tx_data;
            sda_oe_next  = ~tx_data[7];
            bit_cnt_next = '0;
            phase_next   = 1'b0;
            state_next   = RD_DATA;
          end
        end
        IGNORE: sda_oe_next = 1'b0;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master against the target responder.
module tb_i2c_slave_responder;

  localparam int Q = 20;  // quarter SCL period in ref_clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       start_det;
  logic       stop_det;
  logic       busy;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int rxv_cnt = 0, txr_cnt = 0, start_cnt = 0, stop_cnt = 0, busy_cyc = 0;

  // Open-drain bus: either side pulling low wins.
  assign sda_line = sda_m & ~sda_oe;

  always #10 clk = ~clk;

  i2c_slave_responder dut (
    .ref_clk(clk), .reset_n(reset_n), .scl_in(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_req(tx_req), .start_det(start_det), .stop_det(stop_det), .busy(busy)
  );

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid)  rxv_cnt   <= rxv_cnt + 1;
    if (tx_req)    txr_cnt   <= txr_cnt + 1;
    if (start_det) start_cnt <= start_cnt + 1;
    if (stop_det)  stop_cnt  <= stop_cnt + 1;
    if (busy)      busy_cyc  <= busy_cyc + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // glitch: 0 none, 1 short SCL low pulse, 2 short SDA low pulse, both while SCL is high
  task automatic send_bit(input logic b, input int glitch);
    sda_m = b;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    if (glitch == 1) begin scl = 1'b0;   wait_clk(2); scl = 1'b1;   end
    if (glitch == 2) begin sda_m = 1'b0; wait_clk(2); sda_m = 1'b1; end
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1;
    wait_clk(Q);
    scl = 1'b1;
    wait_clk(Q);
    b = sda_line;
    wait_clk(Q);
    scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
    $display("bus START");
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
    $display("bus STOP");
  endtask

  task automatic write_byte(input logic [7:0] b, input int scl_g, input int sda_g, output logic ack);
    for (int i = 7; i >= 0; i--)
      send_bit(b[i], (i == scl_g) ? 1 : ((i == sda_g) ? 2 : 0));
    recv_bit(ack);
    $display("write 0x%02h ack_level=%0b", b, ack);
  endtask

  task automatic read_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) recv_bit(d[i]);
    tx_data = next_tx;
    send_bit(mack, 0);
    $display("read 0x%02h master_ack_level=%0b", d, mack);
  endtask

  task automatic test_reset();
    wait_clk(5);
    check_cnt++; if (sda_oe !== 1'b0)    $display("FAIL reset_sda_oe got %0b want 0", sda_oe); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h00)  $display("FAIL reset_rx_data got %02h want 00", rx_data); else pass_cnt++;
    check_cnt++; if (rx_valid !== 1'b0)  $display("FAIL reset_rx_valid got %0b want 0", rx_valid); else pass_cnt++;
    check_cnt++; if (tx_req !== 1'b0)    $display("FAIL reset_tx_req got %0b want 0", tx_req); else pass_cnt++;
    check_cnt++; if (start_det !== 1'b0) $display("FAIL reset_start_det got %0b want 0", start_det); else pass_cnt++;
    check_cnt++; if (stop_det !== 1'b0)  $display("FAIL reset_stop_det got %0b want 0", stop_det); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)      $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    reset_n = 1'b1;
    wait_clk(20);
    $display("reset released");
  endtask

  task automatic test_write();
    logic a0, a1;
    int rx0, st0, sp0;
    rx0 = rxv_cnt; st0 = start_cnt; sp0 = stop_cnt;
    i2c_start();
    write_byte(8'h84, -1, -1, a0);
    check_cnt++; if (a0 !== 1'b0)   $display("FAIL wr_addr_ack got %0b want 0", a0); else pass_cnt++;
    check_cnt++; if (busy !== 1'b1) $display("FAIL wr_busy got %0b want 1", busy); else pass_cnt++;
    write_byte(8'hA5, -1, -1, a1);
    check_cnt++; if (a1 !== 1'b0)   $display("FAIL wr_data_ack got %0b want 0", a1); else pass_cnt++;
    i2c_stop();
    wait_clk(10);
    check_cnt++; if (rx_data !== 8'hA5)      $display("FAIL wr_rx_data got %02h want a5", rx_data); else pass_cnt++;
    check_cnt++; if (rxv_cnt - rx0 !== 1)    $display("FAIL wr_rx_valid_count got %0d want 1", rxv_cnt - rx0); else pass_cnt++;
    check_cnt++; if (start_cnt - st0 !== 1)  $display("FAIL wr_start_count got %0d want 1", start_cnt - st0); else pass_cnt++;
    check_cnt++; if (stop_cnt - sp0 !== 1)   $display("FAIL wr_stop_count got %0d want 1", stop_cnt - sp0); else pass_cnt++;
    check_cnt++; if (sda_oe !== 1'b0)        $display("FAIL wr_end_sda_oe got %0b want 0", sda_oe); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)          $display("FAIL wr_end_busy got %0b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_addr_mismatch();
    logic a0, a1;
    int rx0, sp0, b0;
    rx0 = rxv_cnt; sp0 = stop_cnt; b0 = busy_cyc;
    i2c_start();
    write_byte(8'h86, -1, -1, a0);
    check_cnt++; if (a0 !== 1'b1) $display("FAIL nm_addr_ack got %0b want 1", a0); else pass_cnt++;
    write_byte(8'h55, -1, -1, a1);
    check_cnt++; if (a1 !== 1'b1) $display("FAIL nm_data_ack got %0b want 1", a1); else pass_cnt++;
    check_cnt++; if (rxv_cnt - rx0 !== 0)   $display("FAIL nm_rx_valid_count got %0d want 0", rxv_cnt - rx0); else pass_cnt++;
    check_cnt++; if (busy_cyc - b0 !== 0)   $display("FAIL nm_busy_cycles got %0d want 0", busy_cyc - b0); else pass_cnt++;
    i2c_stop();
    wait_clk(10);
    check_cnt++; if (stop_cnt - sp0 !== 1)  $display("FAIL nm_stop_count got %0d want 1", stop_cnt - sp0); else pass_cnt++;
    check_cnt++; if (sda_oe !== 1'b0)       $display("FAIL nm_sda_oe got %0b want 0", sda_oe); else pass_cnt++;
  endtask

  task automatic test_read();
    logic a0;
    logic [7:0] d1, d2;
    int tr0, sp0;
    tr0 = txr_cnt; sp0 = stop_cnt;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, -1, -1, a0);
    check_cnt++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack got %0b want 0", a0); else pass_cnt++;
    read_byte(1'b0, 8'hC3, d1);
    check_cnt++; if (d1 !== 8'h3C) $display("FAIL rd_byte1 got %02h want 3c", d1); else pass_cnt++;
    read_byte(1'b1, 8'h00, d2);
    check_cnt++; if (d2 !== 8'hC3) $display("FAIL rd_byte2 got %02h want c3", d2); else pass_cnt++;
    check_cnt++; if (txr_cnt - tr0 !== 2) $display("FAIL rd_tx_req_count got %0d want 2", txr_cnt - tr0); else pass_cnt++;
    check_cnt++; if (sda_oe !== 1'b0)     $display("FAIL rd_nack_sda_oe got %0b want 0", sda_oe); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)       $display("FAIL rd_nack_busy got %0b want 0", busy); else pass_cnt++;
    i2c_stop();
    wait_clk(10);
    check_cnt++; if (stop_cnt - sp0 !== 1) $display("FAIL rd_stop_count got %0d want 1", stop_cnt - sp0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic a0, a1, a2, a3;
    logic [7:0] d;
    int st0;
    st0 = start_cnt;
    i2c_start();
    write_byte(8'h84, -1, -1, a0);
    write_byte(8'h11, -1, -1, a1);
    tx_data = 8'h7E;
    i2c_start();
    write_byte(8'h85, -1, -1, a2);
    read_byte(1'b1, 8'h00, d);
    i2c_stop();
    wait_clk(10);
    a3 = a0 | a1 | a2;
    check_cnt++; if (a3 !== 1'b0)           $display("FAIL rs_acks got %0b want 0", a3); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h11)     $display("FAIL rs_rx_data got %02h want 11", rx_data); else pass_cnt++;
    check_cnt++; if (start_cnt - st0 !== 2) $display("FAIL rs_start_count got %0d want 2", start_cnt - st0); else pass_cnt++;
    check_cnt++; if (d !== 8'h7E)           $display("FAIL rs_read got %02h want 7e", d); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic a0, a1;
    int rx0, st0;
    rx0 = rxv_cnt; st0 = start_cnt;
    i2c_start();
    write_byte(8'h84, -1, -1, a0);
    // 0x5A: SCL glitch during bit 3, SDA low glitch during bit 6 (a '1' with SCL high)
    write_byte(8'h5A, 3, 6, a1);
    i2c_stop();
    wait_clk(10);
    check_cnt++; if (a1 !== 1'b0)           $display("FAIL gl_ack got %0b want 0", a1); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h5A)     $display("FAIL gl_rx_data got %02h want 5a", rx_data); else pass_cnt++;
    check_cnt++; if (rxv_cnt - rx0 !== 1)   $display("FAIL gl_rx_valid_count got %0d want 1", rxv_cnt - rx0); else pass_cnt++;
    check_cnt++; if (start_cnt - st0 !== 1) $display("FAIL gl_start_count got %0d want 1", start_cnt - st0); else pass_cnt++;
  endtask

  task automatic test_reset_midway();
    logic a0, a1;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i), 0);
    check_cnt++; if (sda_oe !== 1'b1) $display("FAIL mr_ack_driven got %0b want 1", sda_oe); else pass_cnt++;
    #3 reset_n = 1'b0;
    #1;
    check_cnt++; if (sda_oe !== 1'b0) $display("FAIL mr_async_release got %0b want 0", sda_oe); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0)   $display("FAIL mr_async_busy got %0b want 0", busy); else pass_cnt++;
    $display("reset asserted mid-ACK");
    scl = 1'b1; sda_m = 1'b1;
    wait_clk(10);
    reset_n = 1'b1;
    wait_clk(20);
    i2c_start();
    write_byte(8'h84, -1, -1, a0);
    write_byte(8'h99, -1, -1, a1);
    i2c_stop();
    wait_clk(10);
    check_cnt++; if (a0 !== 1'b0)       $display("FAIL mr_addr_ack got %0b want 0", a0); else pass_cnt++;
    check_cnt++; if (a1 !== 1'b0)       $display("FAIL mr_data_ack got %0b want 0", a1); else pass_cnt++;
    check_cnt++; if (rx_data !== 8'h99) $display("FAIL mr_rx_data got %02h want 99", rx_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_addr_mismatch();
    test_read();
    test_back_to_back();
    test_glitch();
    test_reset_midway();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
